// File: rtl/lights_board_if.sv
// Bus between the Lights Out game engine and its cursor/display side.
// The master drives cursor, button, new-game and row select; the slave reports board state.
interface lights_board_if #(
    parameter int MOVE_W = 10
);
    logic [5:0]        Position;
    logic              Toggle;
    logic              New_game;
    logic [63:0]       Pattern;
    logic [2:0]        Row_sel;
    logic [7:0]        Row_data;
    logic [63:0]       Board;
    logic              Busy;
    logic              Won;
    logic [MOVE_W-1:0] Moves;

    modport master (
        output Position, Toggle, New_game, Pattern, Row_sel,
        input  Row_data, Board, Busy, Won, Moves
    );

    modport slave (
        input  Position, Toggle, New_game, Pattern, Row_sel,
        output Row_data, Board, Busy, Won, Moves
    );
endinterface

// File: rtl/lights_board.sv
// 8x8 Lights Out game-state engine: plus-toggle, move counter, win detect, row readback.
// Define LIGHTS_SCRAMBLE_EN to replace Pattern loading with an LFSR-driven random scramble.
module lights_board #(
    parameter int MOVE_W         = 10,
    parameter int SCRAMBLE_MOVES = 20
) (
    input logic           clk,
    input logic           reset,
    lights_board_if.slave bus
);

`ifdef LIGHTS_SCRAMBLE_EN
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, SCRAMBLE} state_e;
    localparam int CNT_W = $clog2(SCRAMBLE_MOVES + 1);
`else
    typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_e;
`endif

    state_e            state_q, state_d;
    logic [63:0]       board_q, board_d;
    logic [MOVE_W-1:0] moves_q, moves_d;
    logic              won_q, won_d;
    logic [5:0]        pos_q, pos_d;
    logic              loaded_q, loaded_d;
    logic              tog_q;
    logic [7:0]        row_data_q;
    logic              tog_edge;

`ifdef LIGHTS_SCRAMBLE_EN
    logic [15:0]      lfsr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Plus-shaped toggle footprint; edges of the board do not wrap.
    function automatic logic [63:0] plus_mask(input logic [5:0] p);
        logic [63:0] m;
        m    = '0;
        m[p] = 1'b1;
        if (p[2:0] != 3'd0) m[p - 6'd1] = 1'b1;
        if (p[2:0] != 3'd7) m[p + 6'd1] = 1'b1;
        if (p[5:3] != 3'd0) m[p - 6'd8] = 1'b1;
        if (p[5:3] != 3'd7) m[p + 6'd8] = 1'b1;
        return m;
    endfunction

    assign tog_edge = bus.Toggle & ~tog_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            board_q    <= '0;
            moves_q    <= '0;
            won_q      <= 1'b0;
            pos_q      <= '0;
            loaded_q   <= 1'b0;
            tog_q      <= 1'b0;
            row_data_q <= '0;
`ifdef LIGHTS_SCRAMBLE_EN
            lfsr_q     <= 16'hACE1;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            moves_q    <= moves_d;
            won_q      <= won_d;
            pos_q      <= pos_d;
            loaded_q   <= loaded_d;
            tog_q      <= bus.Toggle;
            row_data_q <= board_q[{bus.Row_sel, 3'b000} +: 8];
`ifdef LIGHTS_SCRAMBLE_EN
            lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            cnt_q      <= cnt_d;
`endif
        end
    end

    // New_game aborts any operation, so it is decoded ahead of the state.
    always_comb begin
        state_d = state_q;
        if (bus.New_game) begin
`ifdef LIGHTS_SCRAMBLE_EN
            state_d = SCRAMBLE;
`else
            state_d = CHECK;
`endif
        end else begin
            unique case (state_q)
                IDLE:     if (tog_edge && !won_q) state_d = APPLY;
                APPLY:    state_d = CHECK;
                CHECK:    state_d = IDLE;
`ifdef LIGHTS_SCRAMBLE_EN
                SCRAMBLE: if (cnt_q <= CNT_W'(1)) state_d = CHECK;
`endif
                default:  state_d = IDLE;
            endcase
        end
    end

    // NOTE: every _d gets a default first so no path through this block infers a latch.
    always_comb begin
        board_d  = board_q;
        moves_d  = moves_q;
        won_d    = won_q;
        pos_d    = pos_q;
        loaded_d = loaded_q;
`ifdef LIGHTS_SCRAMBLE_EN
        cnt_d    = cnt_q;
`endif
        if (bus.New_game) begin
            won_d    = 1'b0;
            moves_d  = '0;
            loaded_d = 1'b1;
`ifdef LIGHTS_SCRAMBLE_EN
            board_d  = '0;
            cnt_d    = CNT_W'(SCRAMBLE_MOVES);
`else
            board_d  = bus.Pattern;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (tog_edge && !won_q) pos_d = bus.Position;
                APPLY: begin
                    board_d  = board_q ^ plus_mask(pos_q);
                    moves_d  = (moves_q == '1) ? moves_q : moves_q + 1'b1;
                    loaded_d = 1'b0;
                end
                // A freshly loaded or scrambled board never counts as a win.
                CHECK: won_d = !loaded_q && (board_q == '0);
`ifdef LIGHTS_SCRAMBLE_EN
                SCRAMBLE: begin
                    board_d = board_q ^ plus_mask(lfsr_q[5:0]);
                    cnt_d   = cnt_q - 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.Busy = (state_q != IDLE);
    end

    assign bus.Board    = board_q;
    assign bus.Won      = won_q;
    assign bus.Moves    = moves_q;
    assign bus.Row_data = row_data_q;

endmodule

// File: tb/tb_lights_board.sv
// Directed self-checking bench for lights_board with hand-computed board images.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lights_board;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    lights_board_if #(.MOVE_W(10)) bus ();

    lights_board #(.MOVE_W(10), .SCRAMBLE_MOVES(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] CORNER   = 64'h0000_0000_0000_0103;
    localparam logic [63:0] INTERIOR = 64'h0000_0008_1C08_0000;
    localparam logic [63:0] FAR      = 64'hC080_0000_0000_0000;
    localparam logic [63:0] ABORT_P  = 64'h1234_5678_9ABC_DEF0;

    initial begin
        reset        = 1'b1;
        bus.Position = '0;
        bus.Toggle   = 1'b0;
        bus.New_game = 1'b0;
        bus.Pattern  = '0;
        bus.Row_sel  = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_board", bus.Board, 64'h0);
        check("rst_won", 64'(bus.Won), 64'h0);
        check("rst_moves", 64'(bus.Moves), 64'h0);
        check("rst_rowdata", 64'(bus.Row_data), 64'h0);
        check("rst_busy", 64'(bus.Busy), 64'h0);

        // Corner toggle, with Toggle held high for 10 cycles
        bus.Position = 6'o00;
        bus.Toggle   = 1'b1;
        tick();
        check("corner_busy_n1", 64'(bus.Busy), 64'h1);
        check("corner_board_n1", bus.Board, 64'h0);
        tick();
        check("corner_board_n2", bus.Board, CORNER);
        check("corner_moves_n2", 64'(bus.Moves), 64'h1);
        check("corner_busy_n2", 64'(bus.Busy), 64'h1);
        tick();
        check("corner_busy_n3", 64'(bus.Busy), 64'h0);
        check("corner_won_n3", 64'(bus.Won), 64'h0);
        for (int i = 0; i < 7; i++) tick();
        check("hold_moves", 64'(bus.Moves), 64'h1);
        check("hold_board", bus.Board, CORNER);
        bus.Toggle = 1'b0;

        // Row readback
        bus.Row_sel = 3'd1;
        tick();
        check("row1", 64'(bus.Row_data), 64'h01);
        bus.Row_sel = 3'd0;
        tick();
        check("row0", 64'(bus.Row_data), 64'h03);

        // Second edge while busy is dropped; this toggle also solves the board
        bus.Toggle = 1'b1;
        tick();
        bus.Toggle = 1'b0;
        tick();
        check("drop_board", bus.Board, 64'h0);
        bus.Toggle = 1'b1;
        tick();
        bus.Toggle = 1'b0;
        tick();
        tick();
        check("drop_moves", 64'(bus.Moves), 64'h2);
        check("drop_won", 64'(bus.Won), 64'h1);
        check("drop_busy", 64'(bus.Busy), 64'h0);

        // Loading an all-dark pattern must not report a win
        bus.Pattern  = 64'h0;
        bus.New_game = 1'b1;
        tick();
        bus.New_game = 1'b0;
        check("load0_board", bus.Board, 64'h0);
        check("load0_moves", 64'(bus.Moves), 64'h0);
        check("load0_won", 64'(bus.Won), 64'h0);
        check("load0_busy_n1", 64'(bus.Busy), 64'h1);
        tick();
        check("load0_busy_n2", 64'(bus.Busy), 64'h0);
        check("load0_won_n2", 64'(bus.Won), 64'h0);

        // Interior then far corner
        bus.Position = 6'o33;
        bus.Toggle   = 1'b1;
        tick();
        bus.Toggle = 1'b0;
        tick();
        check("interior_board", bus.Board, INTERIOR);
        tick();
        bus.Position = 6'o77;
        bus.Toggle   = 1'b1;
        tick();
        bus.Toggle = 1'b0;
        tick();
        check("far_board", bus.Board, INTERIOR ^ FAR);
        tick();
        check("far_moves", 64'(bus.Moves), 64'h2);
        check("far_won", 64'(bus.Won), 64'h0);

        // Win and lockout
        bus.Pattern  = 64'h103;
        bus.New_game = 1'b1;
        tick();
        bus.New_game = 1'b0;
        check("win_load_board", bus.Board, 64'h103);
        tick();
        bus.Position = 6'o00;
        bus.Toggle   = 1'b1;
        tick();
        bus.Toggle = 1'b0;
        tick();
        check("win_board", bus.Board, 64'h0);
        check("win_won_n2", 64'(bus.Won), 64'h0);
        tick();
        check("win_won_n3", 64'(bus.Won), 64'h1);
        check("win_moves", 64'(bus.Moves), 64'h1);
        bus.Position = 6'o44;
        bus.Toggle   = 1'b1;
        tick();
        check("lock_busy", 64'(bus.Busy), 64'h0);
        bus.Toggle = 1'b0;
        tick();
        tick();
        check("lock_board", bus.Board, 64'h0);
        check("lock_moves", 64'(bus.Moves), 64'h1);

        // New_game during APPLY aborts it
        bus.Pattern  = 64'h0000_0000_0000_00FF;
        bus.New_game = 1'b1;
        tick();
        bus.New_game = 1'b0;
        tick();
        bus.Position = 6'o11;
        bus.Toggle   = 1'b1;
        tick();
        check("abort_busy_apply", 64'(bus.Busy), 64'h1);
        bus.Toggle   = 1'b0;
        bus.Pattern  = ABORT_P;
        bus.New_game = 1'b1;
        tick();
        bus.New_game = 1'b0;
        check("abort_board", bus.Board, ABORT_P);
        check("abort_moves", 64'(bus.Moves), 64'h0);
        tick();
        tick();
        check("abort_board_idle", bus.Board, ABORT_P);
        check("abort_busy_idle", 64'(bus.Busy), 64'h0);

        // Reset mid-APPLY
        bus.Toggle = 1'b1;
        tick();
        reset      = 1'b1;
        bus.Toggle = 1'b0;
        tick();
        reset = 1'b0;
        check("rstapply_board", bus.Board, 64'h0);
        check("rstapply_moves", 64'(bus.Moves), 64'h0);
        check("rstapply_busy", 64'(bus.Busy), 64'h0);
        check("rstapply_won", 64'(bus.Won), 64'h0);

        // Move counter saturation: board alternates between all-ones and never clears
        bus.Pattern  = '1;
        bus.New_game = 1'b1;
        tick();
        bus.New_game = 1'b0;
        tick();
        bus.Position = 6'o00;
        for (int i = 0; i < 1030; i++) begin
            bus.Toggle = 1'b1;
            tick();
            bus.Toggle = 1'b0;
            tick();
            tick();
        end
        check("sat_moves", 64'(bus.Moves), 64'h3FF);
        check("sat_board", bus.Board, '1);
        check("sat_won", 64'(bus.Won), 64'h0);

`ifdef LIGHTS_SCRAMBLE_EN
        // Reset mid-SCRAMBLE
        bus.New_game = 1'b1;
        tick();
        bus.New_game = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("scr_busy", 64'(bus.Busy), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("scr_rst_board", bus.Board, 64'h0);
        check("scr_rst_busy", 64'(bus.Busy), 64'h0);
        check("scr_rst_rowdata", 64'(bus.Row_data), 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lights_board.md
# lights_board

Game-state engine for the 8x8 Lights Out board. It consumes the cursor `Position` and `Toggle` press produced by the grid cursor counter. It applies the Lights Out "plus" toggle (the cell plus its orthogonal neighbours, no wrap) to a 64-bit light register, counts moves, detects the solved board, and serves row readback to the display driver.

## Interface
- `MOVE_W`, 10: width of the move counter.
- `SCRAMBLE_MOVES`, 20: number of random toggles applied per new game; used only with `LIGHTS_SCRAMBLE_EN`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Position` in 6: cursor. `[5:3]` is the row and `[2:0]` is the column. Cell index = row*8+col.
- `Toggle` in 1: level from the button. Only its rising edge is acted on.
- `New_game` in 1: single-cycle start pulse. It is level-sampled, so each cycle it is high counts.
- `Pattern` in 64: preset board, loaded on `New_game` (non-scramble build only).
- `Row_sel` in 3: display row to read back.
- `Row_data` out 8: registered copy of `Board[Row_sel*8 +: 8]`.
- `Board` out 64: current light state. A 1 means the light is on.
- `Busy` out 1: high while the state is not IDLE.
- `Won` out 1: board solved.
- `Moves` out MOVE_W: accepted toggles since the last new game. Saturates at all-ones.

## Operation
- **Edge detection**
  - `tog_q` holds the previous `Toggle` value.
  - `tog_edge = Toggle & ~tog_q`.
  - `tog_q` updates every cycle in every state.
- **States:** IDLE, APPLY, CHECK, and SCRAMBLE (scramble build only).
- **IDLE**
  - `New_game` has priority over a toggle edge.
  - When `New_game` is high:
    - Clear `Won` and `Moves`.
    - Non-scramble build: load `Board <= Pattern`, then go to CHECK.
    - Scramble build: clear `Board`, load the scramble counter with `SCRAMBLE_MOVES`, then go to SCRAMBLE.
  - When `tog_edge` is high and `Won` is 0: capture `Position` into `pos_q`, then go to APPLY.
  - When `tog_edge` is high and `Won` is 1: ignore it and stay in IDLE.
- **APPLY:** `Board <= Board ^ mask(pos_q)`, increment `Moves` (saturating), then go to CHECK.
- **CHECK:** `Won <= (Board == 0)`, then go to IDLE.
  - After a `New_game` load, CHECK does not assert `Won`. `Won` is forced to 0 whenever the CHECK follows a load or a scramble.
- **mask(p)**
  - Always includes bit p.
  - Includes p-1 if col≠0, p+1 if col≠7, p-8 if row≠0, p+8 if row≠7.
  - A corner cell gives 3 bits, an edge cell 4 bits, an interior cell 5 bits.
- **Toggle edges while `Busy`:** dropped. They are not queued.
- **`New_game` in APPLY, CHECK or SCRAMBLE:** aborts the current operation and behaves exactly like `New_game` in IDLE on that cycle.
- **Row readback:** `Row_data <= Board[Row_sel*8 +: 8]` every cycle in all states.
- **Reset values:**
  - `Board = 0`, `Won = 0`, `Moves = 0`, `Row_data = 0`, `Busy = 0`.
  - State = IDLE, `tog_q = 0`, `pos_q = 0`, LFSR = 16'hACE1.

## Timing
- **Toggle path**
  - `tog_edge` is seen in IDLE at cycle N.
  - `Busy` = 1 at N+1 and N+2.
  - `Board` is updated and visible at N+2.
  - `Moves` is visible at N+2.
  - `Won` is visible at N+3.
  - `Busy` = 0 at N+3.
- **Next toggle:** the earliest next accepted edge is at N+3.
- **Pattern load:** `New_game` at N gives `Board` = `Pattern` at N+1 and `Busy` = 0 at N+2.
- **`Row_data` latency:** 1 cycle from `Row_sel` or `Board` change.
- **Reset:** overrides everything on the same edge, including mid-APPLY and mid-SCRAMBLE.

## Configuration
- **`LIGHTS_SCRAMBLE_EN` defined**
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances every cycle from reset.
  - `New_game` ignores `Pattern` and enters SCRAMBLE.
  - Each SCRAMBLE cycle does `Board ^= mask(lfsr[5:0])` and decrements the counter. `Moves` is not counted.
  - When the counter reaches 0, go to CHECK.
  - Total `Busy` = `SCRAMBLE_MOVES`+1 cycles.
  - The result is always solvable.
- **`LIGHTS_SCRAMBLE_EN` undefined**
  - No LFSR and no SCRAMBLE state.
  - `Pattern` is loaded directly.

## Test plan
- **Corner:** after reset, Position=0, raise Toggle → `Board` = 64'h0000_0000_0000_0103 at N+2, `Moves`=1, `Won`=0.
- **Interior and far corner:** from a zero board, Position=6'o33 → `Board` = 64'h0000_0008_1C08_0000. Then Position=6'o77 → `Board` additionally XORed with 64'hC080_0000_0000_0000.
- **Win and lockout** (non-scramble build):
  - `Pattern`=64'h103, `New_game`, then toggle at Position 0 → `Board`=0, `Won`=1 at N+3, `Moves`=1.
  - A further toggle → no change.
- **Edge/busy filtering:** hold `Toggle` high 10 cycles → exactly one APPLY. A second rising edge at N+1 while `Busy` → dropped, `Moves`=1.
- **Abort and reset:**
  - `New_game` during APPLY → `Board`=`Pattern`, `Moves`=0.
  - `reset` mid-SCRAMBLE → all outputs 0 on the next cycle.
- **Readback:** after the corner toggle, `Row_sel`=1 → `Row_data`=8'h01 one cycle later. `Row_sel`=0 → 8'h03.
